// File: rtl/npc_pkg.sv
// Shared next-PC definitions: npc_op codes, BTB entry record, reset/exception
// defaults and small helpers used by pc_gen and the decode stage.
package npc_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_B   = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_op_e;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

  // Sized for the smallest legal BTB (2 entries); deeper BTBs zero-extend their tag.
  localparam int unsigned BTB_TAG_W = 29;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [31:0]          target;
    logic [1:0]           ctr;
  } btb_entry_t;

  localparam btb_entry_t BTB_ENTRY_RST = '{
    valid:  1'b0,
    tag:    '0,
    target: '0,
    ctr:    2'b01
  };

  function automatic logic [BTB_TAG_W-1:0] btb_tag(input logic [31:0] pc,
                                                   input int unsigned idx_w);
    return BTB_TAG_W'(pc >> (idx_w + 2));
  endfunction

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
    if (up) begin
      return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    end
    return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational actual-successor calculator for a resolving control instruction;
// shared between fetch redirect and the decode stage.
module npc_calc
  import npc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  op,
  input  logic [25:0] i26,
  input  logic [31:0] rs,
  input  logic        taken,
  output logic [31:0] npc
);

  logic [31:0] pc_plus4;
  logic [31:0] br_off;

  always_comb begin
    pc_plus4 = pc + 32'd4;
    br_off   = {{14{i26[15]}}, i26[15:0], 2'b00};
    npc      = pc_plus4;
    case (npc_op_e'(op))
      NPC_SEQ: npc = pc_plus4;
      NPC_B:   npc = taken ? (pc_plus4 + br_off) : pc_plus4;
      NPC_J:   npc = {pc_plus4[31:28], i26, 2'b00};
      NPC_JR:  npc = rs;
      default: npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: exception/return/mispredict redirect with stall, plus an
// optional branch target buffer predictor built when PC_GEN_BTB_EN is defined.
module pc_gen
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic [31:0] res_pred_npc,
  input  logic [1:0]  res_op,
  input  logic [25:0] res_i26,
  input  logic [31:0] res_rs,
  input  logic        res_taken,
  output logic [31:0] f_pc,
  output logic [31:0] f_pred_npc,
  output logic        flush
);

  if (BTB_ENTRIES < 2 || BTB_ENTRIES > 256 ||
      (BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0) begin : g_bad_cfg
    $error("pc_gen: BTB_ENTRIES must be a power of two in 2..256");
  end

  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] act_npc;

  npc_calc u_npc_calc (
    .pc    (res_pc),
    .op    (res_op),
    .i26   (res_i26),
    .rs    (res_rs),
    .taken (res_taken),
    .npc   (act_npc)
  );

  // Held low during reset so a stale resolve cannot look like a redirect.
  always_comb begin
    flush = rst_n && res_valid && (act_npc != res_pred_npc);
  end

  always_comb begin
    f_pc_d = f_pred_npc;
    if (exc_req) begin
      f_pc_d = EXC_VECTOR;
    end else if (eret_req) begin
      f_pc_d = epc;
    end else if (flush) begin
      f_pc_d = act_npc;
    end else if (stall) begin
      f_pc_d = f_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_pc_q <= RESET_PC;
    end else begin
      f_pc_q <= f_pc_d;
    end
  end

  assign f_pc = f_pc_q;

`ifdef PC_GEN_BTB_EN
  localparam int unsigned IDX = $clog2(BTB_ENTRIES);

  btb_entry_t [BTB_ENTRIES-1:0] btb_q, btb_d;
  logic [IDX-1:0] rd_idx, wr_idx;
  btb_entry_t     rd_ent, wr_ent;
  logic           rd_hit, wr_hit, upd_taken;

  // Lookup reads the registered table, so a same-cycle update is seen next cycle.
  always_comb begin
    rd_idx     = f_pc_q[IDX+1:2];
    rd_ent     = btb_q[rd_idx];
    rd_hit     = rd_ent.valid && (rd_ent.tag == btb_tag(f_pc_q, IDX));
    f_pred_npc = (rd_hit && rd_ent.ctr[1]) ? rd_ent.target : f_pc_q + 32'd4;
  end

  always_comb begin
    wr_idx    = res_pc[IDX+1:2];
    wr_ent    = btb_q[wr_idx];
    wr_hit    = wr_ent.valid && (wr_ent.tag == btb_tag(res_pc, IDX));
    upd_taken = (npc_op_e'(res_op) == NPC_B) ? res_taken : 1'b1;
    btb_d     = btb_q;
    if (res_valid && npc_op_e'(res_op) != NPC_SEQ) begin
      if (wr_hit) begin
        wr_ent.ctr = ctr_step(wr_ent.ctr, upd_taken);
        if (upd_taken) begin
          wr_ent.target = act_npc;
        end
        btb_d[wr_idx] = wr_ent;
      end else if (upd_taken) begin
        wr_ent.valid  = 1'b1;
        wr_ent.tag    = btb_tag(res_pc, IDX);
        wr_ent.target = act_npc;
        wr_ent.ctr    = (npc_op_e'(res_op) == NPC_B) ? 2'b10 : 2'b11;
        btb_d[wr_idx] = wr_ent;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btb_q <= {BTB_ENTRIES{BTB_ENTRY_RST}};
    end else begin
      btb_q <= btb_d;
    end
  end
`else
  always_comb begin
    f_pred_npc = f_pc_q + 32'd4;
  end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: reset, directed vector table, hand-written
// redirect/BTB sequences and randomized traffic against a behavioural model.
module tb_pc_gen;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC = 32'h0000_4180;
  localparam int unsigned NENT   = 16;
`ifdef PC_GEN_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, exc_req, eret_req, res_valid, res_taken;
  logic [31:0] epc, res_pc, res_pred_npc, res_rs;
  logic [1:0]  res_op;
  logic [25:0] res_i26;
  logic [31:0] f_pc, f_pred_npc;
  logic        flush;

  always #5 clk = ~clk;

  pc_gen #(
    .RESET_PC    (RST_PC),
    .EXC_VECTOR  (EXC_PC),
    .BTB_ENTRIES (NENT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .exc_req      (exc_req),
    .eret_req     (eret_req),
    .epc          (epc),
    .res_valid    (res_valid),
    .res_pc       (res_pc),
    .res_pred_npc (res_pred_npc),
    .res_op       (res_op),
    .res_i26      (res_i26),
    .res_rs       (res_rs),
    .res_taken    (res_taken),
    .f_pc         (f_pc),
    .f_pred_npc   (f_pred_npc),
    .flush        (flush)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic        last_flush;

  // Reference state: fetch PC and a direct-mapped table remembering the full
  // address of the control instruction that owns each slot.
  logic [31:0] m_pc;
  logic        mv [NENT];
  logic [31:0] ma [NENT];
  logic [31:0] mt [NENT];
  int          mc [NENT];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_succ(input logic [31:0] pc, input logic [1:0] op,
                                           input logic [25:0] i26, input logic [31:0] rs,
                                           input logic tk);
    logic [15:0] imm;
    int          off;
    imm = i26[15:0];
    off = int'($signed(imm));
    case (op)
      2'd1:    return tk ? pc + 32'd4 + 32'(off * 4) : pc + 32'd4;
      2'd2:    return ((pc + 32'd4) & 32'hF000_0000) | ({6'd0, i26} * 32'd4);
      2'd3:    return rs;
      default: return pc + 32'd4;
    endcase
  endfunction

  function automatic int unsigned slot(input logic [31:0] pc);
    return (pc / 4) % NENT;
  endfunction

  function automatic logic [31:0] ref_pred(input logic [31:0] pc);
    int unsigned i;
    i = slot(pc);
    if (BTB_ON && mv[i] && (ma[i] / 4 == pc / 4) && mc[i] >= 2) return mt[i];
    return pc + 32'd4;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC;
    for (int i = 0; i < NENT; i++) begin
      mv[i] = 1'b0; ma[i] = '0; mt[i] = '0; mc[i] = 1;
    end
  endtask

  task automatic model_train(input logic [31:0] succ);
    int unsigned i;
    logic        tk;
    i  = slot(res_pc);
    tk = (res_op == 2'd1) ? res_taken : 1'b1;
    if (mv[i] && (ma[i] / 4 == res_pc / 4)) begin
      mc[i] = tk ? ((mc[i] == 3) ? 3 : mc[i] + 1) : ((mc[i] == 0) ? 0 : mc[i] - 1);
      if (tk) mt[i] = succ;
    end else if (tk) begin
      mv[i] = 1'b1; ma[i] = res_pc; mt[i] = succ;
      mc[i] = (res_op == 2'd1) ? 2 : 3;
    end
  endtask

  task automatic idle();
    stall = 0; exc_req = 0; eret_req = 0; epc = '0;
    res_valid = 0; res_pc = '0; res_pred_npc = '0; res_op = 2'd0;
    res_i26 = '0; res_rs = '0; res_taken = 0;
  endtask

  task automatic res(input logic [31:0] pc, input logic [31:0] pred, input logic [1:0] op,
                     input logic [25:0] i26, input logic [31:0] rs, input logic tk);
    res_valid = 1; res_pc = pc; res_pred_npc = pred; res_op = op;
    res_i26 = i26; res_rs = rs; res_taken = tk;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic [31:0] succ, nxt, pred_now;
    logic        eflush;
    @(negedge clk);
    succ     = ref_succ(res_pc, res_op, res_i26, res_rs, res_taken);
    eflush   = res_valid && (succ != res_pred_npc);
    pred_now = ref_pred(m_pc);
    chk("f_pc", f_pc, m_pc);
    chk("f_pred_npc", f_pred_npc, pred_now);
    chk("flush", {31'd0, flush}, {31'd0, eflush});
    last_flush = flush;
    if (exc_req)       nxt = EXC_PC;
    else if (eret_req) nxt = epc;
    else if (eflush)   nxt = succ;
    else if (stall)    nxt = m_pc;
    else               nxt = pred_now;
    @(posedge clk);
    m_pc = nxt;
    if (BTB_ON && res_valid && res_op != 2'd0) model_train(succ);
    #1;
  endtask

  task automatic goto_pc(input logic [31:0] addr);
    idle();
    res(32'h0000_3100, addr + 32'd8, 2'd3, 26'd0, addr, 1'b0);
    step();
    idle();
    chk("goto_f_pc", f_pc, addr);
  endtask

  typedef struct {
    logic        stall, exc, eret, valid;
    logic [31:0] epc, pc, pred;
    logic [1:0]  op;
    logic [25:0] i26;
    logic [31:0] rs;
    logic        tk;
    logic        exp_flush;
    int          kind;      // 0: next not checked, 1: exp_next, 2: hold
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pre_pc, tmp;
    vecs[0]  = '{0,0,0,1, 32'h0, 32'h3100, 32'h3104, 2'd0, 26'h0, 32'h0, 0, 0, 0, 32'h0};
    vecs[1]  = '{0,0,0,1, 32'h0, 32'h3100, 32'h3108, 2'd0, 26'h0, 32'h0, 0, 1, 1, 32'h3104};
    vecs[2]  = '{0,0,0,1, 32'h0, 32'h3200, 32'h3204, 2'd1, 26'hFFFF, 32'h0, 1, 1, 1, 32'h3200};
    vecs[3]  = '{0,0,0,1, 32'h0, 32'h3200, 32'h3204, 2'd1, 26'hFFFF, 32'h0, 0, 0, 0, 32'h0};
    vecs[4]  = '{0,0,0,1, 32'h0, 32'h0FFF_FFFC, 32'h0, 2'd2, 26'h0, 32'h0, 0, 1, 1, 32'h1000_0000};
    vecs[5]  = '{0,0,0,1, 32'h0, 32'hF000_0FFC, 32'h0, 2'd2, 26'h3FF_FFFF, 32'h0, 0, 1, 1, 32'hFFFF_FFFC};
    vecs[6]  = '{0,0,0,1, 32'h0, 32'h3300, 32'h1234_5678, 2'd3, 26'h0, 32'h1234_5678, 0, 0, 0, 32'h0};
    vecs[7]  = '{1,0,0,1, 32'h0, 32'h3300, 32'h3004, 2'd3, 26'h0, 32'h5000, 0, 1, 1, 32'h5000};
    vecs[8]  = '{1,0,0,0, 32'h0, 32'h0, 32'h0, 2'd0, 26'h0, 32'h0, 0, 0, 2, 32'h0};
    vecs[9]  = '{0,1,1,1, 32'h7770, 32'h3100, 32'h3108, 2'd0, 26'h0, 32'h0, 0, 1, 1, 32'h4180};
    vecs[10] = '{1,0,1,0, 32'h7770, 32'h0, 32'h0, 2'd0, 26'h0, 32'h0, 0, 0, 1, 32'h7770};
    vecs[11] = '{0,0,0,1, 32'h0, 32'hFFFF_FFFC, 32'h0, 2'd1, 26'h0001, 32'h0, 1, 1, 1, 32'h4};
    vecs[12] = '{0,0,0,0, 32'h0, 32'h3100, 32'h3108, 2'd0, 26'h0, 32'h0, 0, 0, 0, 32'h0};
    vecs[13] = '{1,0,1,1, 32'h7770, 32'h3100, 32'h3108, 2'd0, 26'h0, 32'h0, 0, 1, 1, 32'h7770};

    // Reset, with a mismatching resolve present that must not raise flush.
    rst_n = 0;
    idle();
    res(32'h0, 32'h0, 2'd0, 26'h0, 32'h0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_f_pc", f_pc, RST_PC);
    chk("rst_f_pred", f_pred_npc, RST_PC + 32'd4);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    @(posedge clk);
    #1;
    idle();
    rst_n = 1;

    // Sequential fetch after reset.
    chk("seq0", f_pc, 32'h3000);
    step(); chk("seq1", f_pc, 32'h3004);
    step(); chk("seq2", f_pc, 32'h3008);

    // Taken branch mispredict, then refetch of the same branch.
    res(32'h3010, 32'h3014, 2'd1, 26'h4, 32'h0, 1'b1);
    step();
    chk("br_flush", {31'd0, last_flush}, 32'd1);
    chk("br_redirect", f_pc, 32'h3024);
    goto_pc(32'h3010);
    chk("br_refetch_pred", f_pred_npc, BTB_ON ? 32'h3024 : 32'h3014);
    res(32'h3010, f_pred_npc, 2'd1, 26'h4, 32'h0, 1'b1);
    step();
    chk("br_reresolve_flush", {31'd0, last_flush}, BTB_ON ? 32'd0 : 32'd1);

    // Jump allocation (taken flag ignored for J).
    idle();
    res(32'h3020, 32'h3024, 2'd2, 26'h0000C10, 32'h0, 1'b0);
    step();
    chk("j_flush", {31'd0, last_flush}, 32'd1);
    chk("j_redirect", f_pc, 32'h3040);
    goto_pc(32'h3020);
    chk("j_refetch_pred", f_pred_npc, BTB_ON ? 32'h3040 : 32'h3024);
    res(32'h3020, 32'h3040, 2'd2, 26'h0000C10, 32'h0, 1'b0);
    step();
    chk("j_match_flush", {31'd0, last_flush}, 32'd0);

    // Counter decay: allocate at 10, two not-taken resolves, then one taken.
    idle();
    res(32'h3030, 32'h3034, 2'd1, 26'h8, 32'h0, 1'b1);
    step();
    chk("dec_alloc_redirect", f_pc, 32'h3054);
    goto_pc(32'h3030);
    chk("dec_pred_taken", f_pred_npc, BTB_ON ? 32'h3054 : 32'h3034);
    for (int n = 0; n < 2; n++) begin
      res(32'h3030, 32'h3054, 2'd1, 26'h8, 32'h0, 1'b0);
      step();
      chk("dec_nt_flush", {31'd0, last_flush}, 32'd1);
      chk("dec_nt_redirect", f_pc, 32'h3034);
    end
    goto_pc(32'h3030);
    chk("dec_pred_seq", f_pred_npc, 32'h3034);
    res(32'h3030, 32'h3034, 2'd1, 26'h8, 32'h0, 1'b1);
    step();
    goto_pc(32'h3030);
    chk("dec_pred_weak", f_pred_npc, 32'h3034);

    // Directed vector table.
    for (int v = 0; v < 14; v++) begin
      stall = vecs[v].stall; exc_req = vecs[v].exc; eret_req = vecs[v].eret;
      epc = vecs[v].epc; res_valid = vecs[v].valid; res_pc = vecs[v].pc;
      res_pred_npc = vecs[v].pred; res_op = vecs[v].op; res_i26 = vecs[v].i26;
      res_rs = vecs[v].rs; res_taken = vecs[v].tk;
      pre_pc = f_pc;
      step();
      chk($sformatf("vec%0d_flush", v), {31'd0, last_flush}, {31'd0, vecs[v].exp_flush});
      if (vecs[v].kind == 1) chk($sformatf("vec%0d_next", v), f_pc, vecs[v].exp_next);
      if (vecs[v].kind == 2) chk($sformatf("vec%0d_hold", v), f_pc, pre_pc);
    end

    // Reset asserted mid-cycle with a redirect and BTB update pending.
    idle();
    res(32'h3010, 32'h3014, 2'd1, 26'h4, 32'h0, 1'b1);
    exc_req = 1;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_f_pc", f_pc, RST_PC);
    chk("midrst_f_pred", f_pred_npc, RST_PC + 32'd4);
    chk("midrst_flush", {31'd0, flush}, 32'd0);
    @(posedge clk);
    #1;
    idle();
    rst_n = 1;
    model_reset();
    chk("midrst_first_fetch", f_pc, RST_PC);
    step();
    goto_pc(32'h3010);
    chk("midrst_btb_cleared", f_pred_npc, 32'h3014);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      stall     = ($urandom_range(0, 3) == 0);
      exc_req   = ($urandom_range(0, 31) == 0);
      eret_req  = ($urandom_range(0, 31) == 0);
      epc       = 32'h3000 + 4 * $urandom_range(0, 31);
      res_valid = $urandom_range(0, 1) == 1;
      res_pc    = ($urandom_range(0, 7) == 0) ? $urandom : 32'h3000 + 4 * $urandom_range(0, 63);
      res_op    = 2'($urandom_range(0, 3));
      tmp       = $urandom;
      res_i26   = tmp[25:0];
      if ($urandom_range(0, 1) == 1) res_i26[15:0] = 16'($urandom_range(0, 31)) - 16'd16;
      res_rs    = 32'h3000 + 4 * $urandom_range(0, 63);
      res_taken = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 2))
        0:       res_pred_npc = ref_pred(res_pc);
        1:       res_pred_npc = ref_succ(res_pc, res_op, res_i26, res_rs, res_taken);
        default: res_pred_npc = res_rs;
      endcase
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, first fetch address after reset.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h0000_4180, exception entry address.
REQ-003 SHALL have parameter BTB_ENTRIES, default 16, power of two 2..256, branch target buffer depth.
REQ-004 SHALL have ports: clk in 1, clock; rst_n in 1, asynchronous active-low reset.
REQ-005 SHALL have ports: stall in 1, hold fetch; exc_req in 1, exception taken; eret_req in 1, return; epc in 32, return address.
REQ-006 SHALL have ports: res_valid in 1, control instruction resolving; res_pc in 32; res_pred_npc in 32, successor predicted at fetch; res_op in 2, npc_op code; res_i26 in 26; res_rs in 32, jr target; res_taken in 1, branch condition true.
REQ-007 SHALL have ports: f_pc out 32, fetch address; f_pred_npc out 32, predicted successor of f_pc; flush out 1, kill younger instructions.

Function
REQ-008 SHALL encode npc_op as NPC_SEQ=0, NPC_B=1, NPC_J=2, NPC_JR=3.
REQ-009 SHALL compute actual successor: SEQ -> res_pc+4; B -> taken ? res_pc+4+sign-extended(res_i26[15:0])<<2 : res_pc+4; J -> {res_pc+4 [31:28], res_i26, 2'b00}; JR -> res_rs; all arithmetic modulo 2^32.
REQ-010 SHALL assert flush combinationally when res_valid and actual successor != res_pred_npc, otherwise deassert it.
REQ-011 SHALL load f_pc at each clk edge by priority: exc_req -> EXC_VECTOR; eret_req -> epc; flush -> actual successor; stall -> hold; else f_pred_npc.
REQ-012 SHALL override stall with exc_req, eret_req and flush.
REQ-013 SHALL drive f_pred_npc combinationally: BTB hit with counter[1]=1 -> stored target, else f_pc+4.
REQ-014 SHALL index the BTB with f_pc[IDX+1:2], IDX=log2(BTB_ENTRIES); tag is f_pc[31:IDX+2]; hit requires valid and tag match.
REQ-015 SHALL update the BTB on res_valid and res_op != NPC_SEQ, at res_pc's index, including during stall.
REQ-016 SHALL, on update hit, saturate the 2-bit counter up if taken, down otherwise, and rewrite target when taken.
REQ-017 SHALL, on update miss with taken transfer, allocate entry: tag, target, counter 2'b10 for NPC_B, 2'b11 for NPC_J/NPC_JR; miss with not-taken allocates nothing.
REQ-018 SHALL treat J and JR as always taken for counter updates.
REQ-019 SHALL give lookup read-before-write semantics when lookup and update hit the same index in one cycle.
REQ-020 SHALL have zero-cycle prediction latency and one-cycle redirect penalty.

Reset
REQ-021 SHALL, while rst_n low, set f_pc=RESET_PC, f_pred_npc=RESET_PC+4, flush=0, all BTB valid bits 0, all counters 2'b01.
REQ-022 SHALL abandon any in-flight redirect or BTB update when rst_n asserts mid-operation.
REQ-023 SHALL fetch RESET_PC in the first cycle after rst_n deasserts.

Configuration
REQ-024 SHALL use macro PC_GEN_BTB_EN: defined -> BTB built per REQ-013..019; undefined -> no BTB storage, f_pred_npc always f_pc+4, all other behaviour identical.

Structure
REQ-025 SHALL place npc_op codes, BTB entry record (valid, tag, target, counter) and RESET_PC/EXC_VECTOR defaults in shared package npc_pkg.
REQ-026 SHALL implement REQ-009 in combinational sub-module npc_calc, reusable by the decode stage.

Verification
REQ-027 Reset released, no stall, no res_valid -> f_pc 0x3000, 0x3004, 0x3008 on successive cycles.
REQ-028 Branch at 0x3010, i26[15:0]=0x0004, taken, res_pred_npc 0x3014 -> flush=1, next f_pc 0x3024; later fetch of 0x3010 -> f_pred_npc 0x3024.
REQ-029 J at 0x3020, i26=0x0000C10 -> allocate counter 11; refetch 0x3020 -> f_pred_npc 0x00003040, res_pred_npc 0x3040 -> flush=0.
REQ-030 Entry counter 10, branch not taken twice -> counter 00, f_pred_npc = f_pc+4, second resolve flushes to res_pc+4.
REQ-031 stall=1 with simultaneous flush -> f_pc takes actual successor; exc_req with eret_req and flush -> f_pc 0x4180.
REQ-032 PC_GEN_BTB_EN undefined, repeat REQ-028 -> refetch of 0x3010 predicts 0x3014 and flushes again.
